// File: rtl/nibble_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// nibble_stream_reader_pkg
//   Shared definitions for the nibble stream reader: sequencer state
//   encoding and output FIFO sizing / read-credit constants.
//   Revision: 1.0 - initial release
// ============================================================================
package nibble_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Output FIFO depth; also the total number of read credits.
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Credit limit expressed at the width of (occupancy + in-flight reads).
  localparam logic [FIFO_CNT_W:0] FIFO_CREDIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

endpackage
`default_nettype wire

// File: rtl/nibble_stream_reader_skid_fifo.sv
`default_nettype none
// ============================================================================
// nibble_skid_fifo
//   Small synchronous FIFO carrying a data word plus a last flag.
//   Ports:
//     clk, reset           clock / synchronous active-high reset
//     clear                synchronous flush (pointers and occupancy)
//     push, push_data,     write strobe, data word and last flag
//     push_last
//     pop                  read strobe (only when head_valid)
//     head_data, head_last current head entry
//     head_valid           FIFO not empty
//     count                current occupancy
//   Revision: 1.0 - initial release
// ============================================================================
module nibble_skid_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         push_last,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         head_last,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Each entry is {last, data}.
  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is zeroed on reset so the head data reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= {push_last, push_data};
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr][WIDTH-1:0];
  assign head_last  = mem[rd_ptr][WIDTH] & head_valid;

endmodule
`default_nettype wire

// File: rtl/nibble_stream_reader.sv
`default_nettype none
// ============================================================================
// nibble_stream_reader
//   Read-side sequencer for the wide-write/narrow-read frame buffer. Walks a
//   contiguous (wrapping) span of narrow addresses, absorbs the one-cycle RAM
//   read latency and presents the nibbles as a valid/ready stream with last.
//   Ports:
//     clk, reset                 clock / synchronous active-high reset
//     start, base_addr, length   transfer command (sampled while idle)
//     abort                      synchronous cancel
//     busy, done                 transfer status
//     ram_en, ram_addr, ram_data RAM read port (1-cycle latency)
//     out_data, out_valid,       output stream
//     out_ready, out_last
//   Revision: 1.0 - initial release
// ============================================================================
module nibble_stream_reader
  import nibble_stream_reader_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ADDRWIDTH = 10,
  parameter int LENWIDTH  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [LENWIDTH-1:0]  length,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_en,
  output logic [ADDRWIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]     ram_data,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam logic [LENWIDTH-1:0]  LEN_ONE  = LENWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE = ADDRWIDTH'(1);

  state_t                state;
  logic [LENWIDTH-1:0]   remaining;   // reads still to issue
  logic                  ram_last;    // last flag of the read on the bus
  logic                  rd_pend;     // ram_data valid this cycle
  logic                  rd_last;     // last flag travelling with ram_data
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W:0]   inflight;
  logic                  issue;
  logic                  pop;
  logic                  head_last;

  // Credits count FIFO entries plus both pipeline stages (read on the bus and
  // data returning). Pops are ignored, which keeps ram_en free of any path
  // from out_ready while still allowing one read per cycle in steady state.
  assign inflight = {1'b0, fifo_count}
                  + {{FIFO_CNT_W{1'b0}}, ram_en}
                  + {{FIFO_CNT_W{1'b0}}, rd_pend};
  assign issue    = (state == ST_RUN) && (remaining != '0) && (inflight < FIFO_CREDIT);
  assign pop      = out_valid && out_ready;
  assign out_last = head_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_last  <= 1'b0;
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
      remaining <= '0;
    end else begin
      rd_pend <= ram_en;
      rd_last <= ram_last;
      done    <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        ram_en  <= 1'b0;
        rd_pend <= 1'b0;   // discard the return of any read on the bus
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (length == '0) begin
                state <= ST_FINISH;
              end else begin
                // First read goes out straight from the accepting edge.
                state     <= ST_RUN;
                ram_en    <= 1'b1;
                ram_addr  <= base_addr;
                ram_last  <= (length == LEN_ONE);
                remaining <= length - LEN_ONE;
              end
            end
          end
          ST_RUN: begin
            if (issue) begin
              ram_en    <= 1'b1;
              ram_addr  <= ram_addr + ADDR_ONE;
              ram_last  <= (remaining == LEN_ONE);
              remaining <= remaining - LEN_ONE;
            end else begin
              ram_en <= 1'b0;
            end
            if (pop && head_last) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end
          end
          ST_FINISH: begin
            // Entered with done=1 after a normal transfer (pulse ends here),
            // or with done=0 for a zero-length command (pulse starts here).
            done  <= ~done;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  nibble_skid_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (abort),
    .push       (rd_pend),
    .push_data  (ram_data),
    .push_last  (rd_last),
    .pop        (pop),
    .head_data  (out_data),
    .head_last  (head_last),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_nibble_stream_reader.sv
`default_nettype none
// ============================================================================
// tb_nibble_stream_reader
//   Self-checking bench: behavioural RAM, table-driven and random transfers
//   compared against an expected-nibble queue, plus abort/reset/start-while-
//   busy sequences.
//   Revision: 1.0 - initial release
// ============================================================================
module tb_nibble_stream_reader;

  localparam int W  = 4;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_data;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  always #5 clk = ~clk;

  nibble_stream_reader #(.WIDTH(W), .ADDRWIDTH(AW), .LENWIDTH(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Behavioural RAM read port with one-cycle latency.
  logic [W-1:0] mem [1 << AW];
  initial ram_data = '0;
  always @(posedge clk) if (ram_en) ram_data <= mem[ram_addr];

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer, checked cycle by cycle against a queue of expected nibbles
  // built from the RAM contents. glitch>0 pulses a bogus start in that cycle.
  task automatic do_xfer(input logic [AW-1:0] b, input int len, input int pct,
                         input int glitch, input int exp_last);
    logic [W-1:0] expq[$];
    int cyc, issued, got, done_cyc, last_hs, first_v;
    logic pv, pr;
    logic [W-1:0] pd;
    for (int i = 0; i < len; i++) expq.push_back(mem[(int'(b) + i) % (1 << AW)]);
    start     = 1'b1;
    base_addr = b;
    length    = LW'(len);
    out_ready = ($urandom_range(0, 99) < pct);
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    chk("no_done_before_start", done, 0);
    tick();
    start     = 1'b0;
    base_addr = AW'($urandom);
    length    = LW'($urandom);
    cyc = 0; issued = 0; got = 0; done_cyc = -1; last_hs = -1; first_v = -1;
    pv = 1'b0; pr = 1'b0; pd = '0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (ram_en) begin
        if (issued == 0) chk("first_en_cycle", cyc, 1);
        chk("ram_addr", ram_addr, (int'(b) + issued) % (1 << AW));
        issued++;
      end
      chk("outstanding_le4", (issued - got) <= 4, 1);
      if (len == 0) chk("len0_no_valid", out_valid, 0);
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_cycle", cyc, 3);
      end
      if (out_valid && out_ready) begin
        chk("stream_in_range", got < len, 1);
        if (got < len) begin
          chk("data", out_data, expq[got]);
          chk("last", out_last, got == len - 1);
          if (got == len - 1 && exp_last >= 0) chk("table_last_data", out_data, exp_last);
        end
        got++;
        last_hs = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        chk("done_count", got, len);
        chk("done_cycle", cyc, (len == 0) ? 2 : last_hs + 1);
        chk("busy_with_done", busy, len != 0);
        if (pct >= 100 && len > 0) chk("no_bubbles", last_hs, len + 2);
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      tick();
      if (done_cyc >= 0) break;
      start = (cyc == glitch);
      if (start) begin
        base_addr = AW'($urandom);
        length    = LW'($urandom_range(1, 30));
      end
      out_ready = ($urandom_range(0, 99) < pct);
    end
    start = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    chk("issued_total", issued, len);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            pct;
    int            glitch;
    int            exp_last;   // expected final nibble, -1 = from model only
  } vec_t;

  vec_t vecs[8];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = W'($urandom);
    mem[10'h010] = 4'hA; mem[10'h011] = 4'hB; mem[10'h012] = 4'hC;
    mem[10'h013] = 4'hD; mem[10'h014] = 4'hE;
    mem[10'h3FE] = 4'h1; mem[10'h3FF] = 4'h2; mem[10'h000] = 4'h3; mem[10'h001] = 4'h4;

    vecs[0] = '{10'h010, 5,  100, 0, 4'hE};
    vecs[1] = '{10'h3FE, 4,  100, 0, 4'h4};
    vecs[2] = '{10'h080, 8,  50,  0, -1};
    vecs[3] = '{10'h100, 0,  100, 0, -1};
    vecs[4] = '{10'h3FC, 16, 70,  2, -1};
    vecs[5] = '{10'h200, 1,  100, 0, -1};
    vecs[6] = '{10'h123, 9,  30,  3, -1};
    vecs[7] = '{10'h3F0, 12, 100, 2, -1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; length = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    tick();

    for (int v = 0; v < 8; v++)
      do_xfer(vecs[v].base, vecs[v].len, vecs[v].pct, vecs[v].glitch, vecs[v].exp_last);

    // Abort three cycles into a 16-nibble transfer.
    start = 1'b1; base_addr = 10'h040; length = 11'd16; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_ram_en", ram_en, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("abort_quiet", {done, out_valid, ram_en, busy}, 0);
    end
    tick();

    // start and abort together while idle: abort wins.
    start = 1'b1; abort = 1'b1; base_addr = 10'h050; length = 11'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);
    chk("start_abort_ram_en", ram_en, 0);
    tick();
    do_xfer(10'h300, 2, 100, 0, -1);

    // Reset in the middle of a transfer.
    start = 1'b1; base_addr = 10'h2A0; length = 11'd10; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_state", {busy, done, ram_en, out_valid, out_last}, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_out_data", out_data, 0);
    tick();
    do_xfer(10'h2A0, 3, 100, 0, -1);

    // Random transfers.
    for (int r = 0; r < 12; r++)
      do_xfer(AW'($urandom), $urandom_range(0, 20), $urandom_range(25, 100),
              ($urandom_range(0, 1) == 1) ? 2 : 0, -1);

    @(negedge clk);
    chk("final_idle", {busy, done, out_valid, ram_en}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
